// File: rtl/cpu_ctrl_pkg.sv
// Shared ISA constants, ALU operation codes, sequencer states and IR field
// positions for the hardwired control unit.
package cpu_ctrl_pkg;

  localparam int NUM_REGS = 16;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_NOT  = 5'b00010;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00101;
  localparam logic [4:0] ALU_DIV  = 5'b00110;
  localparam logic [4:0] ALU_SHL  = 5'b00111;
  localparam logic [4:0] ALU_SHR  = 5'b01000;
  localparam logic [4:0] ALU_SHRA = 5'b01001;
  localparam logic [4:0] ALU_ROL  = 5'b01010;
  localparam logic [4:0] ALU_ROR  = 5'b01011;
  localparam logic [4:0] ALU_NEG  = 5'b01100;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: run/IR/mem_ready in, control strobes out.
interface control_sequencer_if;
  import cpu_ctrl_pkg::*;

  logic                run;
  logic [31:0]         IR;
  logic                mem_ready;
  logic [NUM_REGS-1:0] Rin, Rout;
  logic                PCout, MARin, IncPC, read, MDRin, MDRout, IRin;
  logic                Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]          alu_op;
  logic                halted;

  modport master (
    input  run, IR, mem_ready,
    output Rin, Rout, PCout, MARin, IncPC, read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, alu_op, halted
  );

  modport slave (
    output run, IR, mem_ready,
    input  Rin, Rout, PCout, MARin, IncPC, read, MDRin, MDRout, IRin,
           Yin, Zin, Zlowout, Zhighout, HIin, LOin, alu_op, halted
  );
endinterface

// File: rtl/opcode_decoder.sv
// Combinational opcode -> ALU operation map plus instruction-class flags.
module opcode_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] op,
  output logic [4:0] alu_op,
  output logic       is_unary,
  output logic       is_muldiv,
  output logic       is_div,
  output logic       illegal
);
  always_comb begin
    alu_op    = ALU_AND;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_div    = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_ROR:  alu_op = ALU_ROR;
      OP_ROL:  alu_op = ALU_ROL;
      OP_SHR:  alu_op = ALU_SHR;
      OP_SHRA: alu_op = ALU_SHRA;
      OP_SHL:  alu_op = ALU_SHL;
      OP_DIV:  begin alu_op = ALU_DIV; is_muldiv = 1'b1; is_div = 1'b1; end
      OP_MUL:  begin alu_op = ALU_MUL; is_muldiv = 1'b1; end
      OP_NEG:  begin alu_op = ALU_NEG; is_unary = 1'b1; end
      OP_NOT:  begin alu_op = ALU_NOT; is_unary = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: T0-T2 fetch, T3-T6 execute, with a
// bounded memory stall and a multi-cycle divide hold in T4.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES   = 34,
  parameter int MEM_WAIT_MAX = 15
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);
  localparam int DW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES + 1) : 1;
  localparam int SW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

  state_e         state;
  logic [DW-1:0]  div_cnt;
  logic [SW-1:0]  stall_cnt;

  logic pc_out, mar_in, inc_pc, rd, mdr_in, mdr_out, ir_in;
  logic z_low, z_high, hi_in, halt_q;

  logic [4:0] op, dec_alu;
  logic [3:0] ra, rb, rc;
  logic       is_unary, is_muldiv, is_div, illegal;
  logic       unused_ir;

  assign op = bus.IR[OP_MSB:OP_LSB];
  assign ra = bus.IR[RA_MSB:RA_LSB];
  assign rb = bus.IR[RB_MSB:RB_LSB];
  assign rc = bus.IR[RC_MSB:RC_LSB];
  assign unused_ir = ^bus.IR[RC_LSB-1:0];

  opcode_decoder u_dec (
    .op       (op),
    .alu_op   (dec_alu),
    .is_unary (is_unary),
    .is_muldiv(is_muldiv),
    .is_div   (is_div),
    .illegal  (illegal)
  );

  // Strobes are registered from the next state; every one defaults low
  // so each is high only in the cycle its state is current.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      div_cnt   <= '0;
      stall_cnt <= '0;
      {pc_out, mar_in, inc_pc, rd, mdr_in, mdr_out, ir_in} <= '0;
      {z_low, z_high, hi_in, halt_q} <= '0;
    end else begin
      {pc_out, mar_in, inc_pc, rd, mdr_in, mdr_out, ir_in} <= '0;
      {z_low, z_high, hi_in, halt_q} <= '0;
      case (state)
        IDLE: if (bus.run) begin
          state <= T0; pc_out <= 1'b1; mar_in <= 1'b1;
        end
        T0: begin
          state <= T1; inc_pc <= 1'b1; rd <= 1'b1; mdr_in <= 1'b1;
          stall_cnt <= '0;
        end
        T1: begin
          if (bus.mem_ready) begin
            state <= T2; mdr_out <= 1'b1; ir_in <= 1'b1;
          end else if (stall_cnt == SW'(MEM_WAIT_MAX)) begin
            state <= HALT; halt_q <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1; rd <= 1'b1; mdr_in <= 1'b1;
          end
        end
        T2: state <= T3;
        T3: begin
          if (illegal) begin
            state <= HALT; halt_q <= 1'b1;
          end else if (is_unary) begin
            state <= T5; z_low <= 1'b1;
          end else begin
            state <= T4; div_cnt <= DW'(DIV_CYCLES - 1);
          end
        end
        T4: begin
          if (is_div && div_cnt != '0) div_cnt <= div_cnt - 1'b1;
          else begin state <= T5; z_low <= 1'b1; end
        end
        T5: begin
          if (is_muldiv) begin
            state <= T6; z_high <= 1'b1; hi_in <= 1'b1;
          end else if (bus.run) begin
            state <= T0; pc_out <= 1'b1; mar_in <= 1'b1;
          end else state <= IDLE;
        end
        T6: begin
          if (bus.run) begin
            state <= T0; pc_out <= 1'b1; mar_in <= 1'b1;
          end else state <= IDLE;
        end
        HALT: halt_q <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  // Register selects depend on IR, which the datapath only loads at the end
  // of T2, so they are decoded from the state and IR registers directly.
  logic [NUM_REGS-1:0] rout, rin;
  logic                y_in, z_in, lo_in;
  logic [4:0]          alu;

  always_comb begin
    rout  = '0;
    rin   = '0;
    y_in  = 1'b0;
    z_in  = 1'b0;
    lo_in = 1'b0;
    alu   = '0;
    case (state)
      T3: if (!illegal) begin
        rout[rb] = 1'b1;
        if (is_unary) begin alu = dec_alu; z_in = 1'b1; end
        else y_in = 1'b1;
      end
      T4: begin
        rout[rc] = 1'b1;
        alu      = dec_alu;
        z_in     = !is_div || (div_cnt == '0);
      end
      T5: if (is_muldiv) lo_in = 1'b1; else rin[ra] = 1'b1;
      default: ;
    endcase
  end

  assign bus.Rout     = rout;
  assign bus.Rin      = rin;
  assign bus.Yin      = y_in;
  assign bus.Zin      = z_in;
  assign bus.LOin     = lo_in;
  assign bus.alu_op   = alu;
  assign bus.PCout    = pc_out;
  assign bus.MARin    = mar_in;
  assign bus.IncPC    = inc_pc;
  assign bus.read     = rd;
  assign bus.MDRin    = mdr_in;
  assign bus.MDRout   = mdr_out;
  assign bus.IRin     = ir_in;
  assign bus.Zlowout  = z_low;
  assign bus.Zhighout = z_high;
  assign bus.HIin     = hi_in;
  assign bus.halted   = halt_q;
endmodule
